// File: rtl/rx_phy_pkg.sv
// Shared 802.11a receive-PHY types and per-rate lookup constants.
package rx_phy_pkg;

  localparam int MAX_CBPS = 288;

  typedef enum logic [1:0] {
    RATE_BPSK  = 2'd0,
    RATE_QPSK  = 2'd1,
    RATE_QAM16 = 2'd2,
    RATE_QAM64 = 2'd3
  } rate_mode_e;

  typedef enum logic {W_IDLE, W_FILL}  wr_state_e;
  typedef enum logic {R_IDLE, R_DRAIN} rd_state_e;

  function automatic logic [8:0] n_cbps(input rate_mode_e m);
    case (m)
      RATE_BPSK:  return 9'd48;
      RATE_QPSK:  return 9'd96;
      RATE_QAM16: return 9'd192;
      default:    return 9'd288;
    endcase
  endfunction

  function automatic logic [2:0] n_bpsc(input rate_mode_e m);
    case (m)
      RATE_BPSK:  return 3'd1;
      RATE_QPSK:  return 3'd2;
      RATE_QAM16: return 3'd4;
      default:    return 3'd6;
    endcase
  endfunction

  // N_CBPS/16: the interleaver column index advances once per col_depth bits.
  function automatic logic [4:0] col_depth(input rate_mode_e m);
    case (m)
      RATE_BPSK:  return 5'd3;
      RATE_QPSK:  return 5'd6;
      RATE_QAM16: return 5'd12;
      default:    return 5'd18;
    endcase
  endfunction

  // s = max(N_BPSC/2, 1): width of the bit-rotation group.
  function automatic logic [1:0] rot_span(input rate_mode_e m);
    logic [2:0] b;
    b = n_bpsc(m);
    return (b > 3'd2) ? b[2:1] : 2'd1;
  endfunction

endpackage

// File: rtl/deint_addr_gen.sv
// Incremental 802.11a (de)interleaver address generator: maps bit index j to
// position k from running counters only, without any divider.
module deint_addr_gen
  import rx_phy_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       advance,
  input  rate_mode_e mode,
  output logic [8:0] addr,
  output logic       last
);

  // rem = j mod D, col = floor(j/D), jms = j mod s, qms = col mod s, with D = N_CBPS/16.
  logic [4:0] rem_q;
  logic [3:0] col_q;
  logic [1:0] jms_q, qms_q;

  logic [4:0] depth_m1;
  logic [1:0] span, span_m1;
  logic [2:0] sum, perm;
  logic [4:0] row;

  assign depth_m1 = col_depth(mode) - 5'd1;
  assign span     = rot_span(mode);
  assign span_m1  = span - 2'd1;
  assign last     = (col_q == 4'd15) && (rem_q == depth_m1);

  // D is a multiple of s, so the rotation stays inside the row: k = 16*(i mod D) + col.
  always_comb begin
    sum  = {1'b0, jms_q} + {1'b0, qms_q};
    perm = (sum >= {1'b0, span}) ? sum - {1'b0, span} : sum;
    row  = rem_q - {3'b000, jms_q} + {2'b00, perm};
    addr = {row, col_q};
  end

  always_ff @(posedge clock) begin
    if (reset || (advance && last)) begin
      rem_q <= '0;
      col_q <= '0;
      jms_q <= '0;
      qms_q <= '0;
    end else if (advance) begin
      jms_q <= (jms_q == span_m1) ? 2'd0 : jms_q + 2'd1;
      if (rem_q == depth_m1) begin
        rem_q <= '0;
        col_q <= col_q + 4'd1;
        qms_q <= (qms_q == span_m1) ? 2'd0 : qms_q + 2'd1;
      end else begin
        rem_q <= rem_q + 5'd1;
      end
    end
  end

endmodule

// File: rtl/deinterleaver_multi.sv
// Rate-adaptive 802.11a receive deinterleaver with ping-pong symbol banks.
// Optional DEINT_ABORT_EN adds an `abort` input that flushes both FSMs.
module deinterleaver_multi #(
  parameter int MAX_CBPS = rx_phy_pkg::MAX_CBPS,
  parameter int AW       = $clog2(MAX_CBPS)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] rate_mode,
  input  logic       in_bit,
  input  logic       in_valid,
`ifdef DEINT_ABORT_EN
  input  logic       abort,
`endif
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  output logic       out_sym_start
);
  import rx_phy_pkg::*;

  wr_state_e wstate, wstate_nx;
  rd_state_e rstate, rstate_nx;

  logic                wb, rb;
  logic [1:0]          full;
  rate_mode_e          bmode [2];
  logic [MAX_CBPS-1:0] mem   [2];

  rate_mode_e in_mode, gen_mode, rd_mode;
  logic [8:0] gen_addr;
  logic       w_last, in_fire, rd_fire, r_last, flush;
  logic [AW-1:0] waddr, raddr, rcnt;
  logic       vld_q, sos_q;

`ifdef DEINT_ABORT_EN
  assign flush = reset | abort;
`else
  assign flush = reset;
`endif

  assign in_mode  = rate_mode_e'(rate_mode);
  assign in_ready = enable & ~reset & ~full[wb];
  assign in_fire  = in_valid & in_ready & ~flush;

  // First bit of a symbol addresses with the live rate_mode; later bits use the latched one.
  assign gen_mode = (wstate == W_IDLE) ? in_mode : bmode[wb];
  assign waddr    = AW'(gen_addr);

  deint_addr_gen u_addr (
    .clock   (clock),
    .reset   (flush),
    .advance (in_fire),
    .mode    (gen_mode),
    .addr    (gen_addr),
    .last    (w_last)
  );

  // An idle reader that sees its bank full reads address 0 in that same cycle,
  // which keeps back-to-back symbols gap-free and gives the 2-cycle latency.
  assign rd_mode = bmode[rb];
  assign rd_fire = enable & full[rb];
  assign raddr   = (rstate == R_IDLE) ? '0 : rcnt;
  assign r_last  = (rstate == R_DRAIN) && (rcnt == AW'(n_cbps(rd_mode) - 9'd1));

  always_comb begin
    wstate_nx = wstate;
    if (in_fire) wstate_nx = w_last ? W_IDLE : W_FILL;
  end

  always_comb begin
    rstate_nx = rstate;
    if (rd_fire) begin
      if (rstate == R_IDLE) rstate_nx = R_DRAIN;
      else if (r_last)      rstate_nx = R_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_nx;
      rstate <= rstate_nx;
    end
  end

  // Bank ownership: the writer only sets an empty bank's flag, the reader only clears a full one.
  always_ff @(posedge clock) begin
    if (flush) begin
      wb       <= 1'b0;
      rb       <= 1'b0;
      full     <= '0;
      rcnt     <= '0;
      bmode[0] <= RATE_BPSK;
      bmode[1] <= RATE_BPSK;
    end else begin
      if (in_fire && (wstate == W_IDLE)) bmode[wb] <= in_mode;
      if (in_fire && w_last) begin
        full[wb] <= 1'b1;
        wb       <= ~wb;
      end
      if (rd_fire) begin
        if (r_last) begin
          full[rb] <= 1'b0;
          rb       <= ~rb;
          rcnt     <= '0;
        end else begin
          rcnt <= (rstate == R_IDLE) ? AW'(1) : rcnt + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (in_fire) mem[wb][waddr] <= in_bit;
  end

  always_ff @(posedge clock) begin
    if (flush) begin
      out_bit <= 1'b0;
      vld_q   <= 1'b0;
      sos_q   <= 1'b0;
    end else if (enable) begin
      vld_q   <= rd_fire;
      sos_q   <= rd_fire && (rstate == R_IDLE);
      out_bit <= rd_fire ? mem[rb][raddr] : 1'b0;
    end
  end

  // A registered bit held across a disable window is presented on the next enabled cycle.
  assign out_valid     = vld_q & enable;
  assign out_sym_start = sos_q & enable;

endmodule

// File: tb/tb_deinterleaver_multi.sv
// Randomized bench for deinterleaver_multi against a formula-level permutation model.
module tb_deinterleaver_multi;

  logic       clock = 1'b0, reset = 1'b1, enable = 1'b1;
  logic [1:0] rate_mode = 2'd0;
  logic       in_bit = 1'b0, in_valid = 1'b0;
  logic       in_ready, out_bit, out_valid, out_sym_start;
`ifdef DEINT_ABORT_EN
  logic       abort = 1'b0;
`endif

  int checks = 0, failures = 0;
  int cyc = 0;
  int vld_cnt = 0, start_cnt = 0, first_vld = -1, last_vld = -1, last_acc = -1;
  int pos = 0, ones = 0, one_pos = -1;
  int NC [4] = '{48, 96, 192, 288};
  bit data_q[$];
  bit exp_q[$];
  bit exps_q[$];

  deinterleaver_multi dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .rate_mode     (rate_mode),
    .in_bit        (in_bit),
    .in_valid      (in_valid),
`ifdef DEINT_ABORT_EN
    .abort         (abort),
`endif
    .in_ready      (in_ready),
    .out_bit       (out_bit),
    .out_valid     (out_valid),
    .out_sym_start (out_sym_start)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Spec address map with plain division.
  function automatic int ref_k(input int n, input int j);
    int s, i;
    s = ((n / 48) / 2 > 1) ? (n / 48) / 2 : 1;
    i = s * (j / s) + (j + (16 * j) / n) % s;
    return 16 * i - (n - 1) * ((16 * i) / n);
  endfunction

  always @(negedge clock) begin
    if (out_valid) begin
      vld_cnt++;
      if (first_vld < 0) first_vld = cyc;
      last_vld = cyc;
      if (out_sym_start) begin
        start_cnt++;
        pos = 0;
      end
      if (out_bit) begin
        ones++;
        one_pos = pos;
      end
      pos++;
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        chk("out_bit", out_bit, exp_q.pop_front());
        chk("sym_start", out_sym_start, exps_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic build(input int mode, input int hot);
    data_q.delete();
    for (int j = 0; j < NC[mode]; j++)
      data_q.push_back((hot < 0) ? 1'($urandom_range(0, 1)) : (j == hot));
  endtask

  task automatic expect_sym(input int mode);
    bit o [0:287];
    int n;
    n = NC[mode];
    for (int j = 0; j < n; j++) o[ref_k(n, j)] = data_q[j];
    for (int r = 0; r < n; r++) begin
      exp_q.push_back(o[r]);
      exps_q.push_back(r == 0);
    end
  endtask

  // Presents data_q[0..count-1]; called between a posedge and the following negedge.
  task automatic feed(input int mode, input int count, input bit wobble);
    int j, guard;
    bit acc;
    j = 0;
    guard = 0;
    rate_mode = 2'(mode);
    in_bit = data_q[0];
    in_valid = 1'b1;
    while (j < count && guard < 1500) begin
      @(negedge clock);
      acc = in_ready;
      if (acc) last_acc = cyc;
      tick(1);
      guard++;
      if (acc) begin
        j++;
        if (j < count) begin
          in_bit = data_q[j];
          if (wobble) rate_mode = 2'($urandom_range(0, 3));
        end
      end
    end
    in_valid = 1'b0;
    in_bit = 1'b0;
    chk("feed_done", j, count);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while (exp_q.size() > 0 && g < 3000) begin
      tick(1);
      g++;
    end
    chk("drain", exp_q.size(), 0);
    tick(4);
  endtask

  task automatic onehot(input int mode, input int hot, input int exp_pos, input string tag);
    int t;
    build(mode, hot);
    ones = 0;
    one_pos = -1;
    first_vld = -1;
    feed(mode, NC[mode], 1'b0);
    t = last_acc;
    expect_sym(mode);
    wait_drain();
    chk({tag, "_pos"}, one_pos, exp_pos);
    chk({tag, "_ones"}, ones, 1);
    chk({tag, "_lat"}, first_vld - t, 2);
  endtask

  initial begin
    int snap, m, g;
    tick(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_sym_start", out_sym_start, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", in_ready, 1);
    tick(1);

    onehot(0, 3, 1, "bpsk3");
    onehot(0, 1, 16, "bpsk1");
    onehot(3, 18, 17, "qam64_18");
    onehot(3, 2, 32, "qam64_2");

    // Back-to-back QPSK stream.
    vld_cnt = 0; start_cnt = 0; first_vld = -1;
    for (int s = 0; s < 10; s++) begin
      build(1, -1);
      feed(1, 96, 1'b0);
      expect_sym(1);
    end
    wait_drain();
    chk("stream_cnt", vld_cnt, 960);
    chk("stream_span", last_vld - first_vld + 1, 960);
    chk("stream_starts", start_cnt, 10);

    // 64-QAM followed by BPSK: third symbol must stall until the big bank drains.
    build(3, -1); feed(3, 288, 1'b0); expect_sym(3);
    build(0, -1); feed(0, 48, 1'b0); expect_sym(0);
    @(negedge clock);
    chk("shrink_ready_lo", in_ready, 0);
    tick(1);
    build(0, -1); feed(0, 48, 1'b0); expect_sym(0);
    wait_drain();

    // Reset in the middle of a 16-QAM symbol.
    build(2, -1);
    feed(2, 100, 1'b0);
    reset = 1'b1;
    tick(1);
    @(negedge clock);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ready", in_ready, 0);
    tick(2);
    reset = 1'b0;
    vld_cnt = 0;
    @(negedge clock);
    chk("midrst_ready_up", in_ready, 1);
    tick(1);
    build(2, -1); feed(2, 192, 1'b0); expect_sym(2);
    wait_drain();
    chk("midrst_cnt", vld_cnt, 192);

    // Enable low for 7 cycles mid-drain.
    build(1, -1); feed(1, 96, 1'b0); expect_sym(1);
    g = 0;
    while (exp_q.size() > 60 && g < 500) begin tick(1); g++; end
    enable = 1'b0;
    snap = exp_q.size();
    for (int c = 0; c < 7; c++) begin
      @(negedge clock);
      chk("en_off_valid", out_valid, 0);
      tick(1);
    end
    chk("en_off_hold", exp_q.size(), snap);
    enable = 1'b1;
    wait_drain();

    // Mid-symbol rate_mode changes must be ignored.
    build(3, -1); feed(3, 288, 1'b1); expect_sym(3);
    wait_drain();

    // Random rate mix.
    for (int s = 0; s < 8; s++) begin
      m = $urandom_range(0, 3);
      build(m, -1); feed(m, NC[m], 1'b0); expect_sym(m);
    end
    wait_drain();

`ifdef DEINT_ABORT_EN
    build(1, -1);
    feed(1, 60, 1'b0);
    abort = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
    tick(1);
    abort = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    snap = vld_cnt;
    tick(150);
    chk("abort_no_out", vld_cnt - snap, 0);
    build(1, -1); feed(1, 96, 1'b0); expect_sym(1);
    wait_drain();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/deinterleaver_multi.md
# deinterleaver_multi

Rate-adaptive 802.11a receive deinterleaver for the PHY_RX chain. It accepts one coded bit per cycle from the demapper and buffers a full OFDM symbol in a ping-pong memory. It writes each bit to its deinterleaved position and streams the reordered symbol serially to the Viterbi decoder. It generalises the fixed-rate deinterleaver to all four 802.11a modulations: N_CBPS ∈ {48, 96, 192, 288} is selected per symbol, and the block handles back-pressure when the symbol size changes.

## Interface
- MAX_CBPS, 288, bank depth in bits; must be ≥ the largest N_CBPS in use.
- AW, $clog2(MAX_CBPS), bank address width.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- enable  in  1  global advance; low freezes all state, forces out_valid=0 and in_ready=0.
- rate_mode  in  2  modulation: 0=BPSK (48/1), 1=QPSK (96/2), 2=16-QAM (192/4), 3=64-QAM (288/6); values are N_CBPS/N_BPSC. Sampled on the first bit of each symbol only.
- in_bit  in  1  coded bit.
- in_valid  in  1  in_bit is present; the bit is accepted when in_valid & in_ready & enable.
- in_ready  out  1  write bank is available.
- out_bit  out  1  deinterleaved bit.
- out_valid  out  1  out_bit is valid. There is no downstream back-pressure.
- out_sym_start  out  1  pulses with the first out_bit of each symbol.

## Operation
- Two banks of MAX_CBPS bits, with independent writer and reader FSMs. Bank ownership is tracked by per-bank full flags and a stored mode.
- Writer FSM:
  - W_IDLE: on the first accepted bit, latch rate_mode into the bank's mode register, set j=0, and go to W_FILL.
  - W_FILL: write the accepted bit to bank[wb][k(j)] and increment j.
  - On j = N_CBPS−1: set full[wb], toggle wb, return to W_IDLE.
- Address map per bit: s = max(N_BPSC/2, 1); i = s·⌊j/s⌋ + (j + ⌊16j/N_CBPS⌋) mod s; k = 16i − (N_CBPS−1)·⌊16i/N_CBPS⌋.
- in_ready = enable & ~reset & ~full[wb].
- Reader FSM:
  - R_IDLE: when full[rb], load that bank's mode, set r=0, go to R_DRAIN.
  - R_DRAIN: read bank[rb][r] sequentially and increment r.
  - On r = N_CBPS−1: clear full[rb], toggle rb, return to R_IDLE. If the other bank is already full, go straight to R_DRAIN with no gap cycle.
- Simultaneous events:
  - A full-clear by the reader and a write-select by the writer in the same cycle: in_ready rises on the following cycle (no combinational path from reader to in_ready).
  - A full-set and a reader idle check in the same cycle: the reader sees full on the next cycle.
- Mode change: a smaller symbol following a larger one may fill before the larger one drains. in_ready then stays low until the old bank is released. No bits are lost or duplicated.
- rate_mode changes mid-symbol are ignored.
- Reset mid-symbol: both full flags clear, both FSMs return to IDLE, partial data is discarded, and outputs go to reset values on the next edge.

## Timing
- Reset values: out_bit=0, out_valid=0, out_sym_start=0, in_ready=0 while reset is high, in_ready=1 on the first cycle after reset with enable=1.
- Memory read is registered. The first out_bit of a symbol appears 2 cycles after its last input bit is accepted.
- Sustained throughput is 1 bit/cycle with no bubbles for constant rate_mode.
- out_valid runs for exactly N_CBPS consecutive enabled cycles per symbol.

## Configuration
- DEINT_ABORT_EN:
  - Defined: adds input port `abort` (1 bit). abort=1 has reset-equivalent effect on both FSMs and full flags on the next edge; out_valid=0 on the next cycle. abort has priority over in_valid.
  - Undefined: the port is absent and there is no abort logic.

## Structure
- Package rx_phy_pkg holds:
  - the rate_mode encoding enum;
  - N_CBPS and N_BPSC lookup constants;
  - MAX_CBPS.
- Sub-module deint_addr_gen maps (j, rate_mode) to k. It runs incrementally from counters: a ⌊16j/N_CBPS⌋ column counter, mod-s, and a row offset. It uses no dividers and is also reused by the transmit interleaver.

## Test plan
- BPSK one-hot: 48 bits with a 1 only at input index 3 → a single out_bit=1 at output position 1. Repeat with index 1 → output position 16.
- 64-QAM one-hot: 288 bits with a 1 at input index 18 → out_bit=1 at output position 17; index 2 → output position 32.
- Streaming: 10 back-to-back QPSK symbols with random data → 960 out_valid cycles, gap-free, matching the golden model file bit-exact. out_sym_start appears every 96 cycles.
- Mode shrink: a 64-QAM symbol immediately followed by BPSK symbols → in_ready low after the 48th BPSK bit until the 64-QAM bank is released, then both symbols are output in order.
- Reset after 100 bits of a 16-QAM symbol → out_valid=0 and in_ready=0 during reset. The next full symbol is output correctly with no residue.
- enable=0 for 7 cycles mid-drain → output pauses and resumes with the same bit sequence. With DEINT_ABORT_EN, abort mid-fill → no output for the aborted symbol.
